trigger_arbiter: RTL and testbench

// - Multi-channel successor of the single trigger counter. NUM_CH event counters, one per downstream instance.
// - Each counter accepts a multi-event delta every cycle. An arbiter grants one pending channel per cycle.
// - Sits in front of a module's execution slot: several upstream stages trigger instances in the same cycle; one instance is issued per cycle.

---
 rtl/trigger_arbiter_pkg.sv | 15 +
 rtl/trigger_arbiter_rr_arbiter.sv | 40 ++++
 rtl/trigger_arbiter.sv | 138 +++++++++++++
 tb/tb_trigger_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_arbiter_pkg.sv
// Shared definitions for the trigger arbiter and its arbitration sub-block.
// Holds the arbitration mode encoding and the index-width helper.
package trigger_arbiter_pkg;

    typedef enum logic {
        TRIG_RR   = 1'b0,
        TRIG_PRIO = 1'b1
    } trig_mode_e;

    // Index width that never collapses to zero, so a single channel still gets a 1-bit id.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trigger_arbiter_rr_arbiter.sv
// Combinational arbiter: picks one request, starting the search at i_ptr (round-robin)
// or at index 0 (fixed priority). Produces the grant as one-hot and as an index.
module rr_arbiter
    import trigger_arbiter_pkg::*;
#(
    parameter int         N    = 4,
    parameter trig_mode_e MODE = TRIG_RR,
    localparam int        IDW  = clog2_min1(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant_onehot,
    output logic [IDW-1:0] o_grant_id,
    output logic           o_any
);

    int w_start;
    int w_idx;

    // Walk the requests once, wrapping from N-1 back to 0; the first hit wins.
    always_comb begin
        o_grant_onehot = '0;
        o_grant_id     = '0;
        o_any          = 1'b0;
        w_start        = (MODE == TRIG_PRIO) ? 0 : int'(i_ptr);
        w_idx          = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = w_start + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!o_any && i_req[w_idx]) begin
                o_any                 = 1'b1;
                o_grant_id            = IDW'(w_idx);
                o_grant_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trigger_arbiter.sv
// Multi-channel trigger counter: per-channel saturating event counters fed by
// per-cycle deltas, with one pending channel issued per cycle through an arbiter.
module trigger_arbiter
    import trigger_arbiter_pkg::*;
#(
    parameter int  NUM_CH  = 4,
    parameter int  CNT_W   = 8,
    parameter int  DELTA_W = 2,
    parameter int  MODE    = 0,
    localparam int ID_W    = clog2_min1(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*DELTA_W-1:0] delta,
    output logic [NUM_CH-1:0]         delta_ready,
    input  logic                      pop_ready,
    output logic                      pop_valid,
    output logic [ID_W-1:0]           pop_id,
    output logic [NUM_CH-1:0]         pop_onehot,
    output logic [NUM_CH*CNT_W-1:0]   count,
    output logic [NUM_CH-1:0]         overflow
);

    // Handshake: an event leaves on a rising edge where pop_valid && pop_ready; pop_ready
    // alone does nothing, and while pop_valid && !pop_ready the grant is held unchanged.
    // delta_ready[i] high promises channel i can absorb a full DELTA_MAX on the next edge.

    localparam trig_mode_e       ARB_MODE  = (MODE == 1) ? TRIG_PRIO : TRIG_RR;
    localparam logic [CNT_W:0]   CNT_MAX_X = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W-1:0] READY_LIM = {CNT_W{1'b1}} - CNT_W'({DELTA_W{1'b1}});

    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_ovf;
    logic [NUM_CH-1:0] r_ready;
    logic              r_pop_valid;
    logic [ID_W-1:0]   r_pop_id;
    logic [NUM_CH-1:0] r_pop_onehot;
    logic [ID_W-1:0]   r_rr_ptr;

    logic              w_pop;
    logic              w_hold;
    logic [NUM_CH-1:0] w_dec;
    logic [CNT_W:0]    w_sum [NUM_CH];
    logic [CNT_W-1:0]  w_new_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_sat;
    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_ready;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [NUM_CH-1:0] w_gnt_onehot;
    logic [ID_W-1:0]   w_gnt_id;
    logic              w_gnt_any;
    logic [ID_W-1:0]   w_pop_id_nxt;
    logic [NUM_CH-1:0] w_pop_onehot_nxt;

    assign w_pop  = pop_ready & r_pop_valid;
    assign w_hold = r_pop_valid & ~pop_ready;
    assign w_dec  = w_pop ? r_pop_onehot : '0;

    // The granted channel always holds a nonzero count, so the pop decrement cannot underflow.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum[i] = {1'b0, r_cnt[i]}
                     + {{(CNT_W + 1 - DELTA_W){1'b0}}, delta[i*DELTA_W +: DELTA_W]}
                     - {{CNT_W{1'b0}}, w_dec[i]};
            w_sat[i]     = (w_sum[i] > CNT_MAX_X);
            w_new_cnt[i] = w_sat[i] ? {CNT_W{1'b1}} : w_sum[i][CNT_W-1:0];
            w_req[i]     = (w_new_cnt[i] != '0);
            w_ready[i]   = (w_new_cnt[i] <= READY_LIM);
        end
    end

    always_comb begin
        w_ptr_nxt = r_rr_ptr;
        if (w_pop) begin
            w_ptr_nxt = (r_pop_id == ID_W'(NUM_CH - 1)) ? '0 : r_pop_id + ID_W'(1);
        end
    end

    rr_arbiter #(
        .N    (NUM_CH),
        .MODE (ARB_MODE)
    ) u_arb (
        .i_req          (w_req),
        .i_ptr          (w_ptr_nxt),
        .o_grant_onehot (w_gnt_onehot),
        .o_grant_id     (w_gnt_id),
        .o_any          (w_gnt_any)
    );

    // A stalled grant is kept as-is so a consumer never sees the id change under it.
    always_comb begin
        w_pop_id_nxt     = r_pop_id;
        w_pop_onehot_nxt = w_gnt_onehot;
        if (w_hold) begin
            w_pop_onehot_nxt = r_pop_onehot;
        end else if (w_gnt_any) begin
            w_pop_id_nxt = w_gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_ovf        <= '0;
            r_ready      <= '1;
            r_pop_valid  <= 1'b0;
            r_pop_id     <= '0;
            r_pop_onehot <= '0;
            r_rr_ptr     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= w_new_cnt[i];
            end
            r_ovf        <= r_ovf | w_sat;
            r_ready      <= w_ready;
            r_pop_valid  <= w_gnt_any;
            r_pop_id     <= w_pop_id_nxt;
            r_pop_onehot <= w_pop_onehot_nxt;
            r_rr_ptr     <= w_ptr_nxt;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            count[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    assign delta_ready = r_ready;
    assign pop_valid   = r_pop_valid;
    assign pop_id      = r_pop_id;
    assign pop_onehot  = r_pop_onehot;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_trigger_arbiter.sv
// Directed bench for trigger_arbiter: three instances (round-robin, small-counter
// saturation, fixed priority) checked against hand-computed expected states.
module tb_trigger_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // dut 0: round-robin, 8-bit counters
    logic [7:0]  delta_a;
    logic        pr_a;
    logic [3:0]  dr_a, oh_a, ovf_a;
    logic        pv_a;
    logic [1:0]  id_a;
    logic [31:0] cnt_a;
    // dut 1: round-robin, 4-bit counters
    logic [7:0]  delta_s;
    logic        pr_s;
    logic [3:0]  dr_s, oh_s, ovf_s;
    logic        pv_s;
    logic [1:0]  id_s;
    logic [15:0] cnt_s;
    // dut 2: fixed priority, 8-bit counters
    logic [7:0]  delta_p;
    logic        pr_p;
    logic [3:0]  dr_p, oh_p, ovf_p;
    logic        pv_p;
    logic [1:0]  id_p;
    logic [31:0] cnt_p;

    trigger_arbiter #(.NUM_CH(4), .CNT_W(8), .DELTA_W(2), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .delta(delta_a), .delta_ready(dr_a), .pop_ready(pr_a),
        .pop_valid(pv_a), .pop_id(id_a), .pop_onehot(oh_a), .count(cnt_a), .overflow(ovf_a)
    );
    trigger_arbiter #(.NUM_CH(4), .CNT_W(4), .DELTA_W(2), .MODE(0)) u_s (
        .clk(clk), .rst_n(rst_n), .delta(delta_s), .delta_ready(dr_s), .pop_ready(pr_s),
        .pop_valid(pv_s), .pop_id(id_s), .pop_onehot(oh_s), .count(cnt_s), .overflow(ovf_s)
    );
    trigger_arbiter #(.NUM_CH(4), .CNT_W(8), .DELTA_W(2), .MODE(1)) u_p (
        .clk(clk), .rst_n(rst_n), .delta(delta_p), .delta_ready(dr_p), .pop_ready(pr_p),
        .pop_valid(pv_p), .pop_id(id_p), .pop_onehot(oh_p), .count(cnt_p), .overflow(ovf_p)
    );

    typedef struct {
        int          cyc;
        int          dut;
        string       name;
        logic [31:0] cnt;
        logic        valid;
        logic [1:0]  id;
        logic [3:0]  ovf;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] c8(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [31:0] c4s(input int a, input int b, input int c, input int d);
        return {16'b0, 4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [7:0] dl(input int a, input int b, input int c, input int d);
        return {2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    task automatic check(input exp_t e);
        logic [31:0] a_cnt;
        logic        a_v;
        logic [1:0]  a_id;
        logic [3:0]  a_oh, a_dr, a_ovf, e_oh, e_dr;
        logic [31:0] mask, c;
        int          w, lim;
        w   = 8;
        lim = 252;
        case (e.dut)
            1: begin
                a_cnt = {16'b0, cnt_s}; a_v = pv_s; a_id = id_s;
                a_oh = oh_s; a_dr = dr_s; a_ovf = ovf_s;
                w = 4; lim = 12;
            end
            2: begin
                a_cnt = cnt_p; a_v = pv_p; a_id = id_p;
                a_oh = oh_p; a_dr = dr_p; a_ovf = ovf_p;
            end
            default: begin
                a_cnt = cnt_a; a_v = pv_a; a_id = id_a;
                a_oh = oh_a; a_dr = dr_a; a_ovf = ovf_a;
            end
        endcase
        mask = (32'd1 << w) - 32'd1;
        e_oh = e.valid ? (4'b0001 << e.id) : 4'b0000;
        for (int i = 0; i < 4; i++) begin
            c       = (e.cnt >> (i * w)) & mask;
            e_dr[i] = (c <= 32'(lim));
        end
        n_cmp++;
        if (e.cyc != cyc || a_cnt !== e.cnt || a_v !== e.valid || a_id !== e.id ||
            a_oh !== e_oh || a_dr !== e_dr || a_ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL %s (dut%0d cyc%0d/%0d): got cnt=%h v=%b id=%0d oh=%b rdy=%b ovf=%b want cnt=%h v=%b id=%0d oh=%b rdy=%b ovf=%b",
                     e.name, e.dut, cyc, e.cyc, a_cnt, a_v, a_id, a_oh, a_dr, a_ovf,
                     e.cnt, e.valid, e.id, e_oh, e_dr, e.ovf);
        end
    endtask

    // Monitor: on every falling edge, compare every expectation due for this cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            check(exp_q.pop_front());
        end
    end

    task automatic push_exp(input int dut, input string name, input logic [31:0] ec,
                            input logic ev, input logic [1:0] eid, input logic [3:0] eovf);
        exp_t e;
        e.cyc   = cyc + 1;
        e.dut   = dut;
        e.name  = name;
        e.cnt   = ec;
        e.valid = ev;
        e.id    = eid;
        e.ovf   = eovf;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        delta_a = '0; pr_a = 1'b0;
        delta_s = '0; pr_s = 1'b0;
        delta_p = '0; pr_p = 1'b0;
    endtask

    // One clock: apply inputs to one dut and queue the state expected after the next edge.
    task automatic step(input int dut, input string name, input logic [7:0] d, input logic pr,
                        input logic [31:0] ec, input logic ev, input logic [1:0] eid,
                        input logic [3:0] eovf);
        @(negedge clk);
        #1;
        idle_inputs();
        case (dut)
            1:       begin delta_s = d; pr_s = pr; end
            2:       begin delta_p = d; pr_p = pr; end
            default: begin delta_a = d; pr_a = pr; end
        endcase
        push_exp(dut, name, ec, ev, eid, eovf);
    endtask

    // Reset pulse landing mid-cycle: state must clear before the next rising edge.
    task automatic reset_pulse();
        @(negedge clk);
        #1;
        idle_inputs();
        push_exp(0, "reset_mid", c8(0, 0, 0, 0), 1'b0, 2'd0, 4'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int budget;
        idle_inputs();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        step(0, "reset_state", 8'h00, 1'b0, c8(0, 0, 0, 0), 1'b0, 2'd0, 4'h0);
        step(0, "load", dl(3, 1, 0, 2), 1'b0, c8(3, 1, 0, 2), 1'b1, 2'd0, 4'h0);
        step(0, "load_hold", 8'h00, 1'b0, c8(3, 1, 0, 2), 1'b1, 2'd0, 4'h0);
        reset_pulse();

        // Round-robin fairness; pop_ready while nothing is valid is ignored.
        step(0, "rr_load", dl(1, 1, 1, 1), 1'b1, c8(1, 1, 1, 1), 1'b1, 2'd0, 4'h0);
        step(0, "rr_pop0", 8'h00, 1'b1, c8(0, 1, 1, 1), 1'b1, 2'd1, 4'h0);
        step(0, "rr_pop1", 8'h00, 1'b1, c8(0, 0, 1, 1), 1'b1, 2'd2, 4'h0);
        step(0, "rr_pop2", 8'h00, 1'b1, c8(0, 0, 0, 1), 1'b1, 2'd3, 4'h0);
        step(0, "rr_empty", 8'h00, 1'b1, c8(0, 0, 0, 0), 1'b0, 2'd3, 4'h0);

        // Same-cycle delta and pop on the granted channel.
        step(0, "sc_load", dl(0, 0, 1, 0), 1'b0, c8(0, 0, 1, 0), 1'b1, 2'd2, 4'h0);
        step(0, "sc_dpop", dl(0, 0, 3, 0), 1'b1, c8(0, 0, 3, 0), 1'b1, 2'd2, 4'h0);
        step(0, "sc_drain2", 8'h00, 1'b1, c8(0, 0, 2, 0), 1'b1, 2'd2, 4'h0);
        step(0, "sc_drain1", 8'h00, 1'b1, c8(0, 0, 1, 0), 1'b1, 2'd2, 4'h0);
        step(0, "sc_drain0", 8'h00, 1'b1, c8(0, 0, 0, 0), 1'b0, 2'd2, 4'h0);

        // Backpressure with ch0 and ch2 pending; rr pointer sits at 3 here.
        step(0, "bp_load", dl(2, 0, 1, 0), 1'b0, c8(2, 0, 1, 0), 1'b1, 2'd0, 4'h0);
        for (int k = 0; k < 5; k++) begin
            step(0, "bp_hold", 8'h00, 1'b0, c8(2, 0, 1, 0), 1'b1, 2'd0, 4'h0);
        end
        step(0, "bp_pop0", 8'h00, 1'b1, c8(1, 0, 1, 0), 1'b1, 2'd2, 4'h0);
        step(0, "bp_pop2", 8'h00, 1'b1, c8(1, 0, 0, 0), 1'b1, 2'd0, 4'h0);
        step(0, "bp_pop0b", 8'h00, 1'b1, c8(0, 0, 0, 0), 1'b0, 2'd0, 4'h0);

        // Saturation on 4-bit counters: ready drops at 13, an illegal delta saturates at 15.
        step(1, "sat_1", dl(1, 0, 0, 0), 1'b0, c4s(1, 0, 0, 0), 1'b1, 2'd0, 4'h0);
        for (int k = 1; k <= 4; k++) begin
            step(1, "sat_fill", dl(3, 0, 0, 0), 1'b0, c4s(1 + 3 * k, 0, 0, 0), 1'b1, 2'd0, 4'h0);
        end
        step(1, "sat_ovf", dl(3, 0, 0, 0), 1'b0, c4s(15, 0, 0, 0), 1'b1, 2'd0, 4'h1);
        step(1, "sat_pop", 8'h00, 1'b1, c4s(14, 0, 0, 0), 1'b1, 2'd0, 4'h1);
        step(1, "sat_sticky", 8'h00, 1'b1, c4s(13, 0, 0, 0), 1'b1, 2'd0, 4'h1);
        step(1, "sat_dpop_max", dl(3, 0, 0, 0), 1'b1, c4s(15, 0, 0, 0), 1'b1, 2'd0, 4'h1);

        // Fixed priority: ch1 arriving mid-stream pre-empts ch3 for one grant.
        step(2, "pr_load", dl(0, 0, 0, 3), 1'b0, c8(0, 0, 0, 3), 1'b1, 2'd3, 4'h0);
        step(2, "pr_load5", dl(0, 0, 0, 2), 1'b0, c8(0, 0, 0, 5), 1'b1, 2'd3, 4'h0);
        step(2, "pr_ch1", dl(0, 1, 0, 0), 1'b1, c8(0, 1, 0, 4), 1'b1, 2'd1, 4'h0);
        step(2, "pr_back3", 8'h00, 1'b1, c8(0, 0, 0, 4), 1'b1, 2'd3, 4'h0);
        for (int k = 3; k >= 1; k--) begin
            step(2, "pr_drain", 8'h00, 1'b1, c8(0, 0, 0, k), 1'b1, 2'd3, 4'h0);
        end
        step(2, "pr_empty", 8'h00, 1'b1, c8(0, 0, 0, 0), 1'b0, 2'd3, 4'h0);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
